// File: rtl/aes_block_arbiter.sv
// Round-robin arbiter that lets two block requesters share one AES core.
// One block is in flight at a time. A WAIT timeout aborts the block and sets a sticky error flag.
module aes_block_arbiter #(
   parameter int unsigned TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] req0_data,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req1_data,
   input  logic         req1_valid,
   output logic         req1_ready,
   output logic [127:0] aes_din,
   output logic         aes_start,
   input  logic         aes_done,
   input  logic [127:0] aes_dout,
   output logic [127:0] res_data,
   output logic         res_id,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      DELIVER = 2'd3
   } state_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 32'd1);

   state_t       state_r;
   state_t       state_s;
   logic [127:0] hold_r;
   logic         owner_r;
   logic         prio_r;      // requester that wins when both are valid
   logic [7:0]   timer_r;
   logic [127:0] res_data_r;
   logic         res_id_r;
   logic         res_valid_r;
   logic         err_r;
   logic         grant0_s;
   logic         grant1_s;
   logic         timeout_hit_s;

   assign timeout_hit_s = (timer_r == TIMER_LAST);

   // Grant decode: only in IDLE, at most one requester, round-robin on contention
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (state_r == IDLE) begin
         if (req0_valid && (!req1_valid || (prio_r == 1'b0))) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = req1_valid;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Next-state logic; aes_done has priority over the timeout in WAIT
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant0_s || grant1_s) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: state_s = WAIT;
         WAIT: begin
            if (aes_done) begin
               state_s = DELIVER;
            end else if (timeout_hit_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT;
            end
         end
         DELIVER: begin
            if (res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DELIVER;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath: hold register, timer, result registers, priority pointer, error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_r      <= 128'd0;
         owner_r     <= 1'b0;
         prio_r      <= 1'b0;
         timer_r     <= 8'd0;
         res_data_r  <= 128'd0;
         res_id_r    <= 1'b0;
         res_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant0_s || grant1_s) begin
                  hold_r  <= grant1_s ? req1_data : req0_data;
                  owner_r <= grant1_s;
               end
            end
            ISSUE: timer_r <= 8'd0;
            WAIT: begin
               timer_r <= timer_r + 8'd1;
               if (aes_done) begin
                  res_data_r  <= aes_dout;
                  res_id_r    <= owner_r;
                  res_valid_r <= 1'b1;
               end else if (timeout_hit_s) begin
                  err_r  <= 1'b1;
                  prio_r <= ~owner_r;
               end
            end
            DELIVER: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  prio_r      <= ~owner_r;
               end
            end
            default: hold_r <= hold_r;
         endcase
      end
   end

   assign req0_ready  = grant0_s;
   assign req1_ready  = grant1_s;
   assign aes_din     = hold_r;
   assign aes_start   = (state_r == ISSUE);
   assign busy        = (state_r != IDLE);
   assign res_data    = res_data_r;
   assign res_id      = res_id_r;
   assign res_valid   = res_valid_r;
   assign timeout_err = err_r;

endmodule

// File: tb/tb_aes_block_arbiter.sv
// Directed bench for aes_block_arbiter: one instance with the default TIMEOUT, one with TIMEOUT = 8.
// Both instances share all inputs.
module tb_aes_block_arbiter;

   localparam logic [127:0] D0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D1 = 128'hf0e0d0c0b0a090807060504030201000;
   localparam logic [127:0] R0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] R1 = 128'h0123456789abcdef0123456789abcdef;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] req0_data, req1_data, aes_dout;
   logic         req0_valid, req1_valid, aes_done, res_ready;

   logic         a_req0_ready, a_req1_ready, a_aes_start, a_res_id, a_res_valid, a_busy, a_timeout_err;
   logic [127:0] a_aes_din, a_res_data;
   logic         b_req0_ready, b_req1_ready, b_aes_start, b_res_id, b_res_valid, b_busy, b_timeout_err;
   logic [127:0] b_aes_din, b_res_data;

   int  checks_n   = 0;
   int  failures_n = 0;
   logic exp_id;

   aes_block_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(a_req0_ready),
      .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(a_req1_ready),
      .aes_din(a_aes_din), .aes_start(a_aes_start), .aes_done(aes_done), .aes_dout(aes_dout),
      .res_data(a_res_data), .res_id(a_res_id), .res_valid(a_res_valid), .res_ready(res_ready),
      .busy(a_busy), .timeout_err(a_timeout_err)
   );

   aes_block_arbiter #(.TIMEOUT(8)) dut8 (
      .clk(clk), .reset(reset),
      .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(b_req0_ready),
      .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(b_req1_ready),
      .aes_din(b_aes_din), .aes_start(b_aes_start), .aes_done(aes_done), .aes_dout(aes_dout),
      .res_data(b_res_data), .res_id(b_res_id), .res_valid(b_res_valid), .res_ready(res_ready),
      .busy(b_busy), .timeout_err(b_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks_n++;
      if (got !== exp) begin
         failures_n++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; aes_done = 1'b0; res_ready = 1'b0;
      req0_data = D0; req1_data = D1; aes_dout = 128'd0;
      tick();
      check_value("rst_a_rdy0", {127'd0, a_req0_ready}, 128'd0);
      check_value("rst_a_rdy1", {127'd0, a_req1_ready}, 128'd0);
      check_value("rst_a_start", {127'd0, a_aes_start}, 128'd0);
      check_value("rst_a_din", a_aes_din, 128'd0);
      check_value("rst_a_rdata", a_res_data, 128'd0);
      check_value("rst_a_rid", {127'd0, a_res_id}, 128'd0);
      check_value("rst_a_rvalid", {127'd0, a_res_valid}, 128'd0);
      check_value("rst_a_busy", {127'd0, a_busy}, 128'd0);
      check_value("rst_a_err", {127'd0, a_timeout_err}, 128'd0);
      check_value("rst_b_busy", {127'd0, b_busy}, 128'd0);
      check_value("rst_b_err", {127'd0, b_timeout_err}, 128'd0);
      check_value("rst_b_rvalid", {127'd0, b_res_valid}, 128'd0);
      reset = 1'b0;
   endtask

   initial begin
      // Single requester, done 10 cycles after start, then a stalled result
      do_reset();
      req0_valid = 1'b1;
      #1;
      check_value("a_rdy0_T", {127'd0, a_req0_ready}, 128'd1);
      check_value("a_rdy1_T", {127'd0, a_req1_ready}, 128'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      check_value("a_start_T1", {127'd0, a_aes_start}, 128'd1);
      check_value("a_din_T1", a_aes_din, D0);
      check_value("a_rdy0_T1", {127'd0, a_req0_ready}, 128'd0);
      check_value("a_busy_T1", {127'd0, a_busy}, 128'd1);
      for (int i = 0; i < 9; i++) begin
         tick();
         check_value("a_start_wait", {127'd0, a_aes_start}, 128'd0);
         check_value("a_din_wait", a_aes_din, D0);
      end
      tick();
      aes_done = 1'b1; aes_dout = R0;
      #1;
      check_value("a_rvalid_T11", {127'd0, a_res_valid}, 128'd0);
      tick();
      aes_done = 1'b0; aes_dout = 128'd0;
      check_value("a_rvalid_T12", {127'd0, a_res_valid}, 128'd1);
      check_value("a_rdata_T12", a_res_data, R0);
      check_value("a_rid_T12", {127'd0, a_res_id}, 128'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_value("a_hold_rvalid", {127'd0, a_res_valid}, 128'd1);
         check_value("a_hold_rdata", a_res_data, R0);
         check_value("a_hold_rid", {127'd0, a_res_id}, 128'd0);
         check_value("a_hold_busy", {127'd0, a_busy}, 128'd1);
         check_value("a_hold_rdy", {126'd0, a_req1_ready, a_req0_ready}, 128'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      check_value("a_post_rvalid", {127'd0, a_res_valid}, 128'd0);
      check_value("a_post_busy", {127'd0, a_busy}, 128'd0);
      check_value("a_post_grant", {126'd0, a_req1_ready, a_req0_ready}, 128'd2);

      // Both requesters valid continuously: grants alternate 0,1,0,1
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_id = (i % 2 == 1);
         #1;
         check_value("rr_rdy0", {127'd0, a_req0_ready}, {127'd0, ~exp_id});
         check_value("rr_rdy1", {127'd0, a_req1_ready}, {127'd0, exp_id});
         tick();
         #1;
         check_value("rr_din", a_aes_din, exp_id ? D1 : D0);
         check_value("rr_issue_rdy", {126'd0, a_req1_ready, a_req0_ready}, 128'd0);
         tick();
         aes_done = 1'b1; aes_dout = exp_id ? R1 : R0;
         tick();
         aes_done = 1'b0;
         check_value("rr_rvalid", {127'd0, a_res_valid}, 128'd1);
         check_value("rr_rid", {127'd0, a_res_id}, {127'd0, exp_id});
         check_value("rr_rdata", a_res_data, exp_id ? R1 : R0);
         tick();
      end

      // TIMEOUT = 8 with no aes_done: abort, sticky error, next grant to requester 1
      do_reset();
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         check_value("to_err_early", {127'd0, b_timeout_err}, 128'd0);
         check_value("to_busy", {127'd0, b_busy}, 128'd1);
      end
      tick();
      check_value("to_err", {127'd0, b_timeout_err}, 128'd1);
      check_value("to_busy_idle", {127'd0, b_busy}, 128'd0);
      check_value("to_rvalid", {127'd0, b_res_valid}, 128'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check_value("to_next_grant", {126'd0, b_req1_ready, b_req0_ready}, 128'd2);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      check_value("to_err_sticky", {127'd0, b_timeout_err}, 128'd1);

      // aes_done on the final WAIT cycle wins over the timeout
      do_reset();
      check_value("err_cleared", {127'd0, b_timeout_err}, 128'd0);
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) tick();
      aes_done = 1'b1; aes_dout = R1;
      tick();
      aes_done = 1'b0;
      check_value("edge_rvalid", {127'd0, b_res_valid}, 128'd1);
      check_value("edge_rdata", b_res_data, R1);
      check_value("edge_err", {127'd0, b_timeout_err}, 128'd0);

      // Reset in WAIT, late aes_done after release
      do_reset();
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_value("mid_busy", {127'd0, a_busy}, 128'd0);
      check_value("mid_din", a_aes_din, 128'd0);
      check_value("mid_start", {127'd0, a_aes_start}, 128'd0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      aes_done = 1'b1; aes_dout = R0;
      tick();
      aes_done = 1'b0;
      tick();
      check_value("late_rvalid", {127'd0, a_res_valid}, 128'd0);
      check_value("late_rdata", a_res_data, 128'd0);
      check_value("late_busy", {127'd0, a_busy}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
      $finish;
   end

endmodule

// File: doc/aes_block_arbiter.md
AES_BLOCK_ARBITER -- requirements
Module: aes_block_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 200, max cycles to wait in WAIT for aes_done before abort (legal 2..255).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset; reset high forces the reset state immediately, independent of clk.
REQ-004 req0_data  input  128  16-byte block from requester 0 (RX batcher).
REQ-005 req0_valid  input  1  requester 0 block pending; held by source until accepted.
REQ-006 req0_ready  output  1  accept strobe to requester 0; transfer occurs when req0_valid && req0_ready.
REQ-007 req1_data / req1_valid / req1_ready  128 / 1 / 1  same as REQ-004..006 for requester 1 (TX batcher).
REQ-008 aes_din  output  128  block presented to the shared AES core.
REQ-009 aes_start  output  1  one-cycle start pulse to the AES core.
REQ-010 aes_done  input  1  one-cycle pulse; aes_dout valid in the same cycle.
REQ-011 aes_dout  input  128  AES core result.
REQ-012 res_data  output  128  result block returned to the owner.
REQ-013 res_id  output  1  owner of res_data (0 = requester 0, 1 = requester 1).
REQ-014 res_valid / res_ready  output / input  1 / 1  result handshake; transfer when both high.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 timeout_err  output  1  sticky flag, set on any WAIT timeout.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DELIVER; exactly one transaction in flight.
REQ-018 IDLE: req0_ready / req1_ready are combinational, high only in IDLE, at most one high per cycle, for the granted requester with valid high.
REQ-019 Arbitration: round-robin; when both valid, grant the requester not served last; after reset requester 0 has priority.
REQ-020 On accept (IDLE, valid && ready): latch data into hold register, latch owner id, next state ISSUE.
REQ-021 ISSUE: aes_start = 1 for exactly this cycle; aes_din = hold register, stable from ISSUE until leaving WAIT; clear timer; next state WAIT.
REQ-022 WAIT: timer (8-bit) increments each cycle; on aes_done, register aes_dout into res_data, set res_id = owner, set res_valid, next state DELIVER.
REQ-023 WAIT timeout: if timer reaches TIMEOUT-1 with no aes_done, set timeout_err, discard block, update round-robin pointer to the other requester, next state IDLE, no res_valid.
REQ-024 aes_done and timer reaching TIMEOUT-1 in the same cycle: aes_done wins, no error.
REQ-025 aes_done outside WAIT is ignored; aes_dout sampled only in WAIT.
REQ-026 DELIVER: res_valid, res_data, res_id held stable until res_ready; on res_ready, clear res_valid, update round-robin pointer to the other requester, next state IDLE.
REQ-027 Latency: accept in cycle T, aes_start in T+1, aes_done at T+1+L gives res_valid at T+2+L; new accept possible the cycle after DELIVER handshake.
REQ-028 aes_start is low in every state except ISSUE; req*_ready is low in every state except IDLE.

Reset
REQ-029 On reset: state IDLE; req0_ready, req1_ready, aes_start, res_valid, busy, timeout_err = 0; aes_din, res_data = 0; res_id = 0; timer = 0; round-robin priority = requester 0.
REQ-030 Reset mid-transaction aborts it: in-flight block and any pending result are discarded; a late aes_done arriving in IDLE after reset produces no res_valid.
REQ-031 timeout_err clears only on reset.

Verification
REQ-032 Only req0_valid with data 0x000102...0F, AES done 10 cycles after start -> req0_ready 1 cycle, aes_start at T+1 with aes_din = 0x000102...0F, res_valid at T+12 with res_id = 0.
REQ-033 req0_valid and req1_valid both high continuously, res_ready tied high -> grants alternate 0,1,0,1; each requester gets exactly one ready per transaction.
REQ-034 res_ready held low 5 cycles after res_valid -> res_data/res_id stable, no new req*_ready, busy = 1; on res_ready, IDLE next cycle.
REQ-035 TIMEOUT = 8, aes_done never asserted -> timeout_err = 1 after 8 WAIT cycles, no res_valid, IDLE, next grant goes to other requester.
REQ-036 Reset asserted in WAIT, aes_done pulsed 2 cycles after reset release -> all outputs at reset values, res_valid stays 0.
REQ-037 aes_done in the same cycle the timer hits TIMEOUT-1 -> res_valid asserted, timeout_err stays 0.
